tx_data_arbiter: RTL and testbench
==================================

TX_DATA_ARBITER -- requirements
Module: tx_data_arbiter

Interface
REQ-001 SHALL have parameter C_NUM_CHNL, default 4: number of requesting channels, range 1..12.
REQ-002 SHALL have parameter C_DATA_WIDTH, default 128: beat width in bits; one of 32, 64 or 128.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  input  1  clock; all logic on the rising edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 CHNL_TX_REQ  input  C_NUM_CHNL  per-channel packet request; level, held until the channel's end beat is accepted.
REQ-007 CHNL_TX_GRANT  output  C_NUM_CHNL  one-hot grant, or all zero.
REQ-008 CHNL_TX_DATA  input  C_NUM_CHNL*C_DATA_WIDTH  per-channel beat data; channel c occupies slice c.
REQ-009 CHNL_TX_DATA_VALID  input  C_NUM_CHNL  per-channel beat valid.
REQ-010 CHNL_TX_DATA_START_FLAG  input  C_NUM_CHNL  first beat of packet.
REQ-011 CHNL_TX_DATA_WORD_VALID  input  C_NUM_CHNL*C_DATA_WIDTH/32  per-dword valid.
REQ-012 CHNL_TX_DATA_END_FLAGS  input  C_NUM_CHNL*C_DATA_WIDTH/32  per-dword end-of-packet flag.
REQ-013 CHNL_TX_DATA_READY  output  C_NUM_CHNL  per-channel beat accept.
REQ-014 WR_TX_DATA, WR_TX_DATA_VALID, WR_TX_DATA_START_FLAG, WR_TX_DATA_WORD_VALID, WR_TX_DATA_END_FLAGS  outputs  same widths as one channel  beat to the TX data FIFO write port.
REQ-015 WR_TX_DATA_READY  input  1  FIFO write-port ready.
REQ-016 ARB_ERR  output  1  sticky protocol-error flag.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and XFER.
REQ-018 IDLE: when CHNL_TX_REQ is nonzero, SHALL register a round-robin winner into the grant register and enter XFER on the next edge; REQ-to-GRANT latency is 1 cycle.
REQ-019 Round-robin: search starts at (last winner + 1) mod C_NUM_CHNL; after reset the last winner is C_NUM_CHNL-1, so channel 0 has first priority.
REQ-020 XFER: write-port outputs SHALL be a combinational mux of the granted channel's inputs; WR_TX_DATA_VALID = CHNL_TX_DATA_VALID[g].
REQ-021 CHNL_TX_DATA_READY[g] SHALL equal WR_TX_DATA_READY in XFER; every other READY bit and all READY bits in IDLE SHALL be 0.
REQ-022 In IDLE, WR_TX_DATA_VALID SHALL be 0; the other write-port outputs are don't-care.
REQ-023 A beat is accepted when WR_TX_DATA_VALID and WR_TX_DATA_READY are both high.
REQ-024 An end beat is an accepted beat with (END_FLAGS & WORD_VALID) nonzero. On an end beat the FSM SHALL return to IDLE, clear GRANT on the next edge, and update the last winner.
REQ-025 At least one idle cycle SHALL separate consecutive packets. The channel just served may be re-granted only if no other channel is requesting.
REQ-026 If REQ[g] drops during XFER, the grant SHALL be held until the end beat; packets are never truncated.
REQ-027 ARB_ERR SHALL set on either of these events and hold until reset:
- the first accepted beat of a grant has START_FLAG=0;
- a later accepted beat has START_FLAG=1.
REQ-028 Back-pressure (WR_TX_DATA_READY=0) SHALL stall the transfer with no loss or duplication of beats.

Reset
REQ-029 While RST_N=0, the block SHALL hold: state IDLE, CHNL_TX_GRANT=0, CHNL_TX_DATA_READY=0, WR_TX_DATA_VALID=0, ARB_ERR=0, last winner=C_NUM_CHNL-1.
REQ-030 Reset asserted mid-packet SHALL abort the packet immediately. Sequencing the downstream FIFO reset is the system's responsibility.
REQ-031 Reset release SHALL be synchronised: a 2-flop deassertion synchroniser drives the internal reset.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (IDLE=0, XFER=1) and the clog2 function.
REQ-033 Round-robin selection SHALL be a sub-module, rr_arbiter: inputs request vector and last winner; output one-hot winner.

Verification
REQ-034 Single requester: REQ=4'b0001, 3-beat packet (START on beat 0, END_FLAGS=4'b0100 on beat 2) -> GRANT=0001 one cycle after REQ; 3 beats appear unchanged on WR_TX_*; GRANT=0 the cycle after the end beat.
REQ-035 Fairness: REQ=4'b1111 held, 1-beat packets -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-036 Back-pressure: WR_TX_DATA_READY toggling 1,0,0,1 during a 4-beat packet from channel 2 -> exactly 4 beats accepted, in order; CHNL_TX_DATA_READY[2] tracks WR_TX_DATA_READY; other READY bits stay 0.
REQ-037 Request drop: channel 1 granted, REQ[1] falls after beat 1 of 3 -> grant held through the end beat; ARB_ERR=0.
REQ-038 Protocol error: first beat sent with START_FLAG=0 -> ARB_ERR=1 the next cycle and stays 1 through later clean packets until RST_N=0.
REQ-039 Mid-packet reset: RST_N=0 during beat 1 -> GRANT=0 and WR_TX_DATA_VALID=0 asynchronously; after release with REQ=4'b0110, channel 1 is granted first.

Source files
------------

// File: rtl/tx_data_arbiter_pkg.sv
// Shared definitions for the TX data arbiter: FSM encoding and width helpers.
package tx_data_arbiter_pkg;

    // Arbiter FSM: IDLE waits for requests, XFER streams the granted channel.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Width of a channel index; never narrower than one bit so that a
    // single-channel build still has a legal vector.
    function automatic int idx_width(input int num_chnl);
        return (clog2(num_chnl) < 1) ? 1 : clog2(num_chnl);
    endfunction

endpackage

// File: rtl/tx_data_arbiter_rr.sv
// Round-robin selector: picks the first requester after the last winner.
module rr_arbiter
    import tx_data_arbiter_pkg::*;
#(
    parameter int C_NUM_CHNL = 4,
    localparam int C_IDX_W = idx_width(C_NUM_CHNL)
) (
    input  logic [C_NUM_CHNL-1:0] req,
    input  logic [C_IDX_W-1:0]    last,
    output logic [C_NUM_CHNL-1:0] grant
);

    int  idx;
    logic found;

    // Scan (last+1) .. (last+C_NUM_CHNL) modulo channel count; first hit wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= C_NUM_CHNL; i++) begin
            idx = (int'(last) + i) % C_NUM_CHNL;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_data_arbiter.sv
// Packet-level arbiter that muxes N request channels onto one TX FIFO write
// port. A grant lasts from the idle-cycle arbitration until the end beat.
//
// Handshake: a beat moves when WR_TX_DATA_VALID and WR_TX_DATA_READY are both
// high on a rising edge. VALID never depends on READY; the granted channel's
// CHNL_TX_DATA_READY is WR_TX_DATA_READY passed straight through, so a stalled
// beat stays on the channel's inputs until it is accepted.
module tx_data_arbiter
    import tx_data_arbiter_pkg::*;
#(
    parameter int C_NUM_CHNL   = 4,
    parameter int C_DATA_WIDTH = 128,
    localparam int C_NW        = C_DATA_WIDTH / 32,
    localparam int C_IDX_W     = idx_width(C_NUM_CHNL)
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic [C_NUM_CHNL-1:0]              CHNL_TX_REQ,
    output logic [C_NUM_CHNL-1:0]              CHNL_TX_GRANT,
    input  logic [C_NUM_CHNL*C_DATA_WIDTH-1:0] CHNL_TX_DATA,
    input  logic [C_NUM_CHNL-1:0]              CHNL_TX_DATA_VALID,
    input  logic [C_NUM_CHNL-1:0]              CHNL_TX_DATA_START_FLAG,
    input  logic [C_NUM_CHNL*C_NW-1:0]         CHNL_TX_DATA_WORD_VALID,
    input  logic [C_NUM_CHNL*C_NW-1:0]         CHNL_TX_DATA_END_FLAGS,
    output logic [C_NUM_CHNL-1:0]              CHNL_TX_DATA_READY,
    output logic [C_DATA_WIDTH-1:0]            WR_TX_DATA,
    output logic                               WR_TX_DATA_VALID,
    output logic                               WR_TX_DATA_START_FLAG,
    output logic [C_NW-1:0]                    WR_TX_DATA_WORD_VALID,
    output logic [C_NW-1:0]                    WR_TX_DATA_END_FLAGS,
    input  logic                               WR_TX_DATA_READY,
    output logic                               ARB_ERR,
    output state_t                             DBG_STATE
);

    logic [1:0]            rst_sync;
    logic                  rst_int_n;

    state_t                state_q, state_d;
    logic [C_NUM_CHNL-1:0] grant_q, grant_d;
    logic [C_IDX_W-1:0]    last_q, last_d;
    logic                  first_q, first_d;   // next accepted beat is the first of the grant
    logic                  err_q, err_d;

    logic [C_NUM_CHNL-1:0] arb_grant;
    logic [C_IDX_W-1:0]    gidx;
    logic                  valid_sel;
    logic                  beat_acc;
    logic                  end_beat;

    // Reset asserts immediately, releases two clock edges after RST_N rises.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    rr_arbiter #(
        .C_NUM_CHNL (C_NUM_CHNL)
    ) u_rr (
        .req   (CHNL_TX_REQ),
        .last  (last_q),
        .grant (arb_grant)
    );

    // Write-port mux driven by the one-hot grant register.
    always_comb begin
        gidx                  = '0;
        valid_sel             = 1'b0;
        WR_TX_DATA            = '0;
        WR_TX_DATA_START_FLAG = 1'b0;
        WR_TX_DATA_WORD_VALID = '0;
        WR_TX_DATA_END_FLAGS  = '0;
        for (int c = 0; c < C_NUM_CHNL; c++) begin
            if (grant_q[c]) begin
                gidx                  = C_IDX_W'(c);
                valid_sel             = CHNL_TX_DATA_VALID[c];
                WR_TX_DATA            = CHNL_TX_DATA[c*C_DATA_WIDTH +: C_DATA_WIDTH];
                WR_TX_DATA_START_FLAG = CHNL_TX_DATA_START_FLAG[c];
                WR_TX_DATA_WORD_VALID = CHNL_TX_DATA_WORD_VALID[c*C_NW +: C_NW];
                WR_TX_DATA_END_FLAGS  = CHNL_TX_DATA_END_FLAGS[c*C_NW +: C_NW];
            end
        end
    end

    // Handshake qualification and per-channel ready fan-out.
    always_comb begin
        WR_TX_DATA_VALID   = (state_q == ST_XFER) && valid_sel;
        beat_acc           = WR_TX_DATA_VALID && WR_TX_DATA_READY;
        end_beat           = beat_acc && (|(WR_TX_DATA_END_FLAGS & WR_TX_DATA_WORD_VALID));
        CHNL_TX_DATA_READY = (state_q == ST_XFER) ?
                             (grant_q & {C_NUM_CHNL{WR_TX_DATA_READY}}) : '0;
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the end beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        first_d = first_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|CHNL_TX_REQ) begin
                    state_d = ST_XFER;
                    grant_d = arb_grant;
                    first_d = 1'b1;
                end
            end
            ST_XFER: begin
                if (beat_acc) begin
                    if (first_q && !WR_TX_DATA_START_FLAG) begin
                        err_d = 1'b1;
                    end
                    if (!first_q && WR_TX_DATA_START_FLAG) begin
                        err_d = 1'b1;
                    end
                    first_d = 1'b0;
                    if (end_beat) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        last_d  = gidx;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers; last winner resets to the top channel so channel 0 leads.
    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= C_IDX_W'(C_NUM_CHNL - 1);
            first_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    assign CHNL_TX_GRANT = grant_q;
    assign ARB_ERR       = err_q;
    assign DBG_STATE     = state_q;

endmodule

// File: tb/tb_tx_data_arbiter.sv
// Directed bench for tx_data_arbiter (4 channels, 128-bit beats).
module tb_tx_data_arbiter;
    import tx_data_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 128;
    localparam int NW = W / 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    grant;
    logic [N*W-1:0]  data;
    logic [N-1:0]    valid;
    logic [N-1:0]    start;
    logic [N*NW-1:0] wv;
    logic [N*NW-1:0] endf;
    logic [N-1:0]    ready_o;
    logic [W-1:0]    wr_data;
    logic            wr_valid;
    logic            wr_start;
    logic [NW-1:0]   wr_wv;
    logic [NW-1:0]   wr_endf;
    logic            wr_ready;
    logic            arb_err;
    state_t          dbg_state;

    int checks;
    int errors;
    logic [W-1:0] exp_q[$];

    tx_data_arbiter #(
        .C_NUM_CHNL   (N),
        .C_DATA_WIDTH (W)
    ) dut (
        .CLK                     (clk),
        .RST_N                   (rst_n),
        .CHNL_TX_REQ             (req),
        .CHNL_TX_GRANT           (grant),
        .CHNL_TX_DATA            (data),
        .CHNL_TX_DATA_VALID      (valid),
        .CHNL_TX_DATA_START_FLAG (start),
        .CHNL_TX_DATA_WORD_VALID (wv),
        .CHNL_TX_DATA_END_FLAGS  (endf),
        .CHNL_TX_DATA_READY      (ready_o),
        .WR_TX_DATA              (wr_data),
        .WR_TX_DATA_VALID        (wr_valid),
        .WR_TX_DATA_START_FLAG   (wr_start),
        .WR_TX_DATA_WORD_VALID   (wr_wv),
        .WR_TX_DATA_END_FLAGS    (wr_endf),
        .WR_TX_DATA_READY        (wr_ready),
        .ARB_ERR                 (arb_err),
        .DBG_STATE               (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req   = '0;
        data  = '0;
        valid = '0;
        start = '0;
        wv    = '0;
        endf  = '0;
    endtask

    task automatic clear_ch(input int ch);
        data[ch*W +: W]   = '0;
        valid[ch]         = 1'b0;
        start[ch]         = 1'b0;
        wv[ch*NW +: NW]   = '0;
        endf[ch*NW +: NW] = '0;
    endtask

    task automatic drive_beat(input int ch, input logic [W-1:0] d, input logic v,
                              input logic s, input logic [NW-1:0] e);
        data[ch*W +: W]   = d;
        valid[ch]         = v;
        start[ch]         = s;
        wv[ch*NW +: NW]   = 4'hF;
        endf[ch*NW +: NW] = e;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_all();
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
    endtask

    // Outputs held low while reset is asserted, even with requests present
    task automatic test_reset();
        rst_n    = 1'b0;
        wr_ready = 1'b1;
        clear_all();
        req   = 4'hF;
        valid = 4'hF;
        start = 4'hF;
        #12;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", ready_o); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", arb_err); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        do_reset();
    endtask

    // One channel, 3-beat packet passes through unchanged
    task automatic test_single();
        logic [W-1:0] d;
        req = 4'b0001;
        #4;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_lat: got %b want 0000", grant); end
        step();
        for (int b = 0; b < 3; b++) begin
            d = {4{32'hA000_0000 + 32'(b)}};
            drive_beat(0, d, 1'b1, b == 0, (b == 2) ? 4'b0100 : 4'b0000);
            #4;
            checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL single_grant_b%0d: got %b want 0001", b, grant); end
            checks++; if (wr_data !== d) begin errors++; $display("FAIL single_data_b%0d: got %h want %h", b, wr_data, d); end
            checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL single_valid_b%0d: got %b want 1", b, wr_valid); end
            checks++; if (wr_start !== (b == 0)) begin errors++; $display("FAIL single_start_b%0d: got %b want %b", b, wr_start, b == 0); end
            checks++; if (wr_endf !== ((b == 2) ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_endf_b%0d: got %b", b, wr_endf); end
            checks++; if (ready_o !== 4'b0001) begin errors++; $display("FAIL single_ready_b%0d: got %b want 0001", b, ready_o); end
            step();
        end
        clear_all();
        #4;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_clear: got %b want 0000", grant); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL single_valid_clear: got %b want 0", wr_valid); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", arb_err); end
        step();
    endtask

    // All channels requesting 1-beat packets: order 0,1,2,3,0 with idle gaps
    task automatic test_fairness();
        logic [N-1:0] fair_exp [10];
        logic [W-1:0] d;
        fair_exp = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
        do_reset();
        for (int c = 0; c < N; c++) begin
            drive_beat(c, {4{32'hF000_0000 + 32'(c)}}, 1'b1, 1'b1, 4'b0001);
        end
        req = 4'hF;
        for (int i = 0; i < 10; i++) begin
            #4;
            checks++; if (grant !== fair_exp[i]) begin errors++; $display("FAIL fair_grant_c%0d: got %b want %b", i, grant, fair_exp[i]); end
            for (int c = 0; c < N; c++) begin
                if (fair_exp[i][c]) begin
                    d = {4{32'hF000_0000 + 32'(c)}};
                    checks++; if (wr_data !== d) begin errors++; $display("FAIL fair_data_c%0d: got %h want %h", i, wr_data, d); end
                end
            end
            step();
        end
        clear_all();
        step();
    endtask

    // Ready pattern 1,0,0,1 repeating while channel 2 sends 4 beats
    task automatic test_backpressure();
        logic [3:0]   pat;
        logic [W-1:0] exp;
        int b;
        int acc;
        pat = 4'b1001;
        b   = 0;
        acc = 0;
        for (int k = 0; k < 4; k++) exp_q.push_back({4{32'hB000_0000 + 32'(k)}});
        req = 4'b0100;
        step();
        for (int cyc = 0; cyc < 16 && b < 4; cyc++) begin
            drive_beat(2, {4{32'hB000_0000 + 32'(b)}}, 1'b1, b == 0, (b == 3) ? 4'b1000 : 4'b0000);
            wr_ready = pat[cyc % 4];
            #4;
            checks++; if (ready_o !== {1'b0, wr_ready, 2'b00}) begin errors++; $display("FAIL bp_ready_c%0d: got %b want %b", cyc, ready_o, {1'b0, wr_ready, 2'b00}); end
            checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 1", cyc, wr_valid); end
            if (wr_ready) begin
                exp = exp_q.pop_front();
                checks++; if (wr_data !== exp) begin errors++; $display("FAIL bp_data_c%0d: got %h want %h", cyc, wr_data, exp); end
                b++;
                acc++;
            end
            step();
        end
        req      = '0;
        clear_ch(2);
        wr_ready = 1'b1;
        #4;
        checks++; if (acc !== 4) begin errors++; $display("FAIL bp_accepted: got %0d want 4", acc); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL bp_grant_clear: got %b want 0000", grant); end
        exp_q.delete();
        step();
    endtask

    // Channel 1 drops REQ after beat 1; grant is held to the end beat
    task automatic test_req_drop();
        req = 4'b0010;
        step();
        for (int b = 0; b < 3; b++) begin
            if (b == 2) req = 4'b0000;
            drive_beat(1, {4{32'hC000_0000 + 32'(b)}}, 1'b1, b == 0, (b == 2) ? 4'b0001 : 4'b0000);
            #4;
            checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL drop_grant_b%0d: got %b want 0010", b, grant); end
            step();
        end
        clear_all();
        #4;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL drop_grant_clear: got %b want 0000", grant); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL drop_err: got %b want 0", arb_err); end
        step();
    endtask

    // Missing START sets the sticky error; only reset clears it
    task automatic test_protocol_error();
        req = 4'b0001;
        step();
        drive_beat(0, {4{32'hD000_0000}}, 1'b1, 1'b0, 4'b0001);
        #4;
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL perr_before: got %b want 0", arb_err); end
        step();
        clear_all();
        #4;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b want 1", arb_err); end
        step();
        req = 4'b1000;
        step();
        drive_beat(3, {4{32'hD000_0003}}, 1'b1, 1'b1, 4'b0010);
        #4;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL perr_clean_grant: got %b want 1000", grant); end
        step();
        clear_all();
        #4;
        checks++; if (arb_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b want 1", arb_err); end
        rst_n = 1'b0;
        #2;
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL perr_reset_clear: got %b want 0", arb_err); end
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
    endtask

    // Reset during beat 1 aborts at once; channel 1 wins first afterwards
    task automatic test_mid_reset();
        logic got;
        req = 4'b0001;
        step();
        drive_beat(0, {4{32'hE000_0000}}, 1'b1, 1'b1, 4'b0000);
        step();
        drive_beat(0, {4{32'hE000_0001}}, 1'b1, 1'b0, 4'b0000);
        #2;
        checks++; if (wr_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before: got %b want 1", wr_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant_async: got %b want 0000", grant); end
        checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_async: got %b want 0", wr_valid); end
        checks++; if (ready_o !== 4'b0000) begin errors++; $display("FAIL mid_ready_async: got %b want 0000", ready_o); end
        clear_all();
        req = 4'b0110;
        step();
        step();
        rst_n = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            if (grant !== 4'b0000) got = 1'b1;
        end
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_first_grant: got %b want 0010", grant); end
        drive_beat(1, {4{32'hE100_0000}}, 1'b1, 1'b1, 4'b1000);
        req = 4'b0000;
        step();
        clear_all();
        #4;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL mid_grant_clear: got %b want 0000", grant); end
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", arb_err); end
        step();
    endtask

    // Test sequence and final report
    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        wr_ready = 1'b1;
        clear_all();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_req_drop();
        test_protocol_error();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
